// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong buffer turning bit-reversed SDF FFT frames into natural order.
// Optional REORDER_FFTSHIFT_EN reads each frame starting at bin N/2 so DC lands mid-frame.
module fft_output_reorder #(
   parameter int N     = 64,
   parameter int WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 di_en,
   input  logic [WIDTH-1:0]     di_re,
   input  logic [WIDTH-1:0]     di_im,
   output logic                 do_en,
   output logic [WIDTH-1:0]     do_re,
   output logic [WIDTH-1:0]     do_im,
   output logic [$clog2(N)-1:0] do_index,
   output logic                 do_last,
   output logic                 frame_err
);
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST_CNT = AW'(N - 1);
`ifdef REORDER_FFTSHIFT_EN
   localparam logic [AW-1:0] SHIFT = AW'(N / 2);
`else
   localparam logic [AW-1:0] SHIFT = '0;
`endif
   localparam logic [AW-1:0] LAST_IDX = LAST_CNT ^ SHIFT;
   typedef enum logic {IDLE, READ} state_t;
   state_t state, state_nx;
   logic [AW-1:0] wr_count, wr_addr, rd_count, rd_count_nx, rd_addr, idx_q;
   logic wr_bank, rd_bank, rd_bank_nx, rd_bank_q, rd_valid;
   logic rd_start, abort, wrap, load, overrun;
   logic [2*WIDTH-1:0] bank0 [N];
   logic [2*WIDTH-1:0] bank1 [N];
   logic [2*WIDTH-1:0] q0, q1, rd_data;
   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < AW; i++) wr_addr[i] = wr_count[AW-1-i];
   end
   assign rd_start = di_en && wr_count == LAST_CNT;
   assign abort    = !di_en && wr_count != '0;
   assign rd_addr  = rd_count ^ SHIFT;
   assign rd_data  = rd_bank_q ? q1 : q0;
   // A new frame may only start reading on the cycle the previous read finishes.
   always_comb begin
      wrap        = state == READ && rd_count == LAST_CNT;
      load        = rd_start && (state == IDLE || wrap);
      overrun     = rd_start && !load;
      state_nx    = load ? READ : wrap ? IDLE : state;
      rd_count_nx = (load || wrap) ? '0 : state == READ ? rd_count + 1'b1 : rd_count;
      rd_bank_nx  = load ? wr_bank : rd_bank;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         rd_count  <= '0;
         rd_bank   <= 1'b0;
         wr_count  <= '0;
         wr_bank   <= 1'b0;
         rd_valid  <= 1'b0;
         rd_bank_q <= 1'b0;
         idx_q     <= '0;
         do_en     <= 1'b0;
         do_index  <= '0;
         do_last   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_count  <= rd_count_nx;
         rd_bank   <= rd_bank_nx;
         wr_count  <= di_en ? wr_count + 1'b1 : '0;
         wr_bank   <= rd_start ? ~wr_bank : wr_bank;
         rd_valid  <= state == READ;
         rd_bank_q <= rd_bank;
         idx_q     <= rd_addr;
         do_en     <= rd_valid;
         do_index  <= idx_q;
         do_last   <= rd_valid && idx_q == LAST_IDX;
         frame_err <= abort || overrun;
      end
   end
   always_ff @(posedge clock) begin
      if (di_en && !wr_bank) bank0[wr_addr] <= {di_re, di_im};
      if (di_en && wr_bank) bank1[wr_addr] <= {di_re, di_im};
      q0    <= bank0[rd_addr];
      q1    <= bank1[rd_addr];
      do_re <= rd_data[2*WIDTH-1:WIDTH];
      do_im <= rd_data[WIDTH-1:0];
   end
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: randomized frames checked against a bit-reversal scoreboard (N=16).
module tb_fft_output_reorder;
   localparam int N = 16;
`ifdef REORDER_FFTSHIFT_EN
   localparam bit SHIFT = 1'b1;
`else
   localparam bit SHIFT = 1'b0;
`endif
   typedef struct {
      int          cyc;
      logic [15:0] re;
      logic [15:0] im;
      logic [3:0]  idx;
      logic        last;
   } out_t;
   logic clock = 1'b0, reset_n, di_en, do_en, do_last, frame_err;
   logic [15:0] di_re, di_im, do_re, do_im;
   logic [3:0] do_index;
   int cyc = 0, n_checks = 0, n_fail = 0, err_pulses = 0;
   out_t got[$];
   out_t exp_q[$];
   fft_output_reorder #(.N(N), .WIDTH(16)) dut (
      .clock(clock), .reset_n(reset_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_index(do_index),
      .do_last(do_last), .frame_err(frame_err)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (do_en) got.push_back('{cyc, do_re, do_im, do_index, do_last});
      if (frame_err) err_pulses++;
   end
   function automatic int brev(input int x);
      int r = 0;
      for (int i = 0; i < 4; i++) r = r * 2 + ((x >> i) & 1);
      return r;
   endfunction
   // Output bin k of a frame holds input sample brev(k); first output lands two edges after the last input.
   task automatic send_frame(input int mode, input int tag);
      logic [15:0] r[16];
      logic [15:0] m[16];
      int t, k;
      for (int i = 0; i < 16; i++) begin
         r[i] = mode == 0 ? 16'(brev(i)) : {4'(tag), 12'($urandom)};
         m[i] = mode == 0 ? 16'(-brev(i)) : 16'($urandom);
         di_en = 1'b1; di_re = r[i]; di_im = m[i];
         @(posedge clock); #1;
      end
      di_en = 1'b0;
      t = cyc;
      for (int j = 0; j < 16; j++) begin
         k = SHIFT ? (j ^ 8) : j;
         exp_q.push_back('{t + 2 + j, r[brev(k)], m[brev(k)], 4'(k), j == 15});
      end
   endtask
   task automatic clear_sb();
      got.delete(); exp_q.delete(); err_pulses = 0;
   endtask
   task automatic test_reset();
      @(negedge clock);
      n_checks++; if (do_en !== 1'b0) begin n_fail++; $display("FAIL reset_do_en: got %b want 0", do_en); end
      n_checks++; if (do_last !== 1'b0) begin n_fail++; $display("FAIL reset_do_last: got %b want 0", do_last); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_checks++; if (do_index !== 4'd0) begin n_fail++; $display("FAIL reset_do_index: got %0d want 0", do_index); end
      @(posedge clock); #1 reset_n = 1'b1;
   endtask
   task automatic test_idle();
      clear_sb();
      repeat (100) begin
         @(negedge clock);
         n_checks++;
         if ({do_en, frame_err} !== 2'b00) begin n_fail++; $display("FAIL idle: do_en=%b frame_err=%b want 0 0", do_en, frame_err); end
      end
      @(posedge clock); #1;
   endtask
   task automatic test_single();
      clear_sb();
      send_frame(0, 0);
      repeat (25) @(posedge clock); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got.size()) begin n_fail++; $display("FAIL single[%0d]: missing, want re=%h idx=%0d", i, exp_q[i].re, exp_q[i].idx); end
         else if ({got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last} !== {exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last}) begin
            n_fail++;
            $display("FAIL single[%0d]: got cyc=%0d re=%h im=%h idx=%0d last=%b want cyc=%0d re=%h im=%h idx=%0d last=%b", i,
                     got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last, exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
         end
      end
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got.size(), exp_q.size()); end
   endtask
   task automatic test_back_to_back();
      clear_sb();
      for (int f = 1; f <= 3; f++) send_frame(1, f);
      repeat (25) @(posedge clock); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got.size()) begin n_fail++; $display("FAIL b2b[%0d]: missing, want re=%h idx=%0d", i, exp_q[i].re, exp_q[i].idx); end
         else if ({got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last} !== {exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last}) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got cyc=%0d re=%h im=%h idx=%0d last=%b want cyc=%0d re=%h im=%h idx=%0d last=%b", i,
                     got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last, exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
         end
      end
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp_q.size()); end
      n_checks++; if (err_pulses != 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d pulses want 0", err_pulses); end
   endtask
   task automatic test_abort();
      clear_sb();
      for (int i = 0; i < 5; i++) begin
         di_en = 1'b1; di_re = 16'($urandom); di_im = 16'($urandom);
         @(posedge clock); #1;
      end
      di_en = 1'b0;
      @(posedge clock); #1;
      send_frame(1, 7);
      repeat (25) @(posedge clock); #1;
      n_checks++; if (err_pulses != 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d pulses want 1", err_pulses); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got.size()) begin n_fail++; $display("FAIL abort[%0d]: missing, want re=%h idx=%0d", i, exp_q[i].re, exp_q[i].idx); end
         else if ({got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last} !== {exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last}) begin
            n_fail++;
            $display("FAIL abort[%0d]: got cyc=%0d re=%h im=%h idx=%0d last=%b want cyc=%0d re=%h im=%h idx=%0d last=%b", i,
                     got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last, exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
         end
      end
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_count: got %0d want %0d", got.size(), exp_q.size()); end
   endtask
   task automatic test_reset_mid();
      clear_sb();
      send_frame(1, 9);
      repeat (9) exp_q.pop_back();
      repeat (8) @(posedge clock);
      #1 reset_n = 1'b0;
      @(posedge clock); #1 reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (do_en !== 1'b0) begin n_fail++; $display("FAIL reset_mid_do_en: got %b want 0", do_en); end
      repeat (25) @(posedge clock); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got.size()) begin n_fail++; $display("FAIL reset_mid[%0d]: missing, want re=%h idx=%0d", i, exp_q[i].re, exp_q[i].idx); end
         else if ({got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last} !== {exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last}) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: got cyc=%0d re=%h idx=%0d want cyc=%0d re=%h idx=%0d", i,
                     got[i].cyc, got[i].re, got[i].idx, exp_q[i].cyc, exp_q[i].re, exp_q[i].idx);
         end
      end
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_mid_count: got %0d want %0d", got.size(), exp_q.size()); end
      clear_sb();
      send_frame(1, 3);
      repeat (25) @(posedge clock); #1;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got.size()) begin n_fail++; $display("FAIL post_reset[%0d]: missing, want re=%h idx=%0d", i, exp_q[i].re, exp_q[i].idx); end
         else if ({got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last} !== {exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last}) begin
            n_fail++;
            $display("FAIL post_reset[%0d]: got cyc=%0d re=%h im=%h idx=%0d last=%b want cyc=%0d re=%h im=%h idx=%0d last=%b", i,
                     got[i].cyc, got[i].re, got[i].im, got[i].idx, got[i].last, exp_q[i].cyc, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
         end
      end
      n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL post_reset_count: got %0d want %0d", got.size(), exp_q.size()); end
   endtask
   initial begin
      reset_n = 1'b0; di_en = 1'b0; di_re = '0; di_im = '0;
      repeat (3) @(posedge clock); #1;
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
